// File: rtl/serline_pkg.sv
// Shared definitions for the serial-line transmit path: arbiter FSM encoding
// and the round-robin index helper.
package serline_pkg;

    localparam int MAX_NREQ = 8;

    typedef enum logic [1:0] {
        ARB   = 2'b00,
        WRITE = 2'b01,
        GAP   = 2'b10
    } arb_state_t;

    // Next requester index in round-robin order, wrapping at n rather than at 8.
    function automatic logic [2:0] rr_next(input logic [2:0] idx, input int n);
        return 3'((int'(idx) + 1) % n);
    endfunction

endpackage

// File: rtl/xmt.sv
// Serial character transmitter: start bit, 8 data bits LSB first, stop bit,
// each bit_len clocks long. Line idles high.
module xmt (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bit_len,
    input  logic        start,
    input  logic [7:0]  din,
    output logic        busy,
    output logic        txd
);

    logic [8:0]  shreg;
    logic [3:0]  nbits;
    logic [15:0] timer;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= 1'b0;
            txd   <= 1'b1;
            shreg <= '1;
            nbits <= '0;
            timer <= '0;
        end else if (!busy) begin
            if (start) begin
                busy  <= 1'b1;
                txd   <= 1'b0;
                shreg <= {1'b1, din};
                nbits <= 4'd9;
                timer <= bit_len - 16'd1;
            end
        end else if (timer == 16'd0) begin
            // Nine shifts carry the data bits and the stop bit; the tenth timeout ends the frame.
            timer <= bit_len - 16'd1;
            if (nbits == 4'd0) begin
                busy <= 1'b0;
                txd  <= 1'b1;
            end else begin
                txd   <= shreg[0];
                shreg <= {1'b1, shreg[8:1]};
                nbits <= nbits - 4'd1;
            end
        end else begin
            timer <= timer - 16'd1;
        end
    end

endmodule

// File: rtl/xmtbuf.sv
// Single-byte holding register in front of the transmitter. ready is a
// registered copy of "holding register empty", so it lags a write by one cycle.
module xmtbuf (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bit_len,
    input  logic        write,
    input  logic [7:0]  data,
    output logic        ready,
    output logic        serial_out
);

    logic       hold_full;
    logic [7:0] hold_data;
    logic       busy;
    logic       start;

    assign start = hold_full && !busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_full <= 1'b0;
            hold_data <= '0;
            ready     <= 1'b1;
        end else begin
            if (write && !hold_full) begin
                hold_full <= 1'b1;
                hold_data <= data;
            end else if (start) begin
                hold_full <= 1'b0;
            end
            ready <= !hold_full;
        end
    end

    xmt xmt_0 (
        .clk     (clk),
        .rst     (rst),
        .bit_len (bit_len),
        .start   (start),
        .din     (hold_data),
        .busy    (busy),
        .txd     (serial_out)
    );

endmodule

// File: rtl/xmtarb.sv
// Round-robin arbiter sharing one xmtbuf among NREQ byte producers, with an
// optional per-requester lock so multi-byte messages never interleave.
module xmtarb
    import serline_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       bit_len,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] data,
    input  logic [NREQ-1:0]   lock,
    output logic [NREQ-1:0]   ack,
    output logic [2:0]        owner,
    output logic              locked,
    output logic              serial_out
);

    arb_state_t                state;
    logic                      write;
    logic [7:0]                wdata;
    logic                      ready;
    logic [MAX_NREQ-1:0]       req_x;
    logic [MAX_NREQ-1:0]       lock_x;
    logic [8*MAX_NREQ-1:0]     data_x;
    logic                      found;
    logic [2:0]                winner;
    logic [2:0]                cand;
    logic                      release_lock;

    // Widened copies let a 3-bit owner index them for any legal NREQ.
    assign req_x  = MAX_NREQ'(req);
    assign lock_x = MAX_NREQ'(lock);
    assign data_x = (8*MAX_NREQ)'(data);

    assign release_lock = locked && !lock_x[owner];

    always_comb begin
        found  = 1'b0;
        winner = owner;
        cand   = owner;
        if (locked) begin
            found = !release_lock && req_x[owner];
        end else begin
            // Search starts after the current owner, so the owner comes last.
            for (int k = 0; k < NREQ; k++) begin
                cand = rr_next(cand, NREQ);
                if (!found && req_x[cand]) begin
                    found  = 1'b1;
                    winner = cand;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ARB;
            write  <= 1'b0;
            wdata  <= '0;
            ack    <= '0;
            owner  <= 3'(NREQ - 1);
            locked <= 1'b0;
        end else begin
            write <= 1'b0;
            ack   <= '0;
            unique case (state)
                ARB: begin
                    if (release_lock) begin
                        locked <= 1'b0;
                    end else if (ready && found) begin
                        owner  <= winner;
                        wdata  <= data_x[{winner, 3'b000} +: 8];
                        locked <= lock_x[winner];
                        write  <= 1'b1;
                        ack    <= NREQ'(1) << winner;
                        state  <= WRITE;
                    end
                end
                WRITE:   state <= GAP;
                // ready still reflects the pre-write buffer here, so skip one cycle.
                GAP:     state <= ARB;
                default: state <= ARB;
            endcase
        end
    end

    xmtbuf xmtbuf_0 (
        .clk        (clk),
        .rst        (rst),
        .bit_len    (bit_len),
        .write      (write),
        .data       (wdata),
        .ready      (ready),
        .serial_out (serial_out)
    );

endmodule

// File: tb/tb_xmtarb.sv
// Bench for xmtarb: directed scenarios plus randomized traffic, checked against
// a grant-level arbitration model and a UART line decoder.
module tb_xmtarb;

    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [15:0]       bit_len = 16'd16;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ-1:0]   lock = '0;
    logic [8*NREQ-1:0] data = '0;
    logic [NREQ-1:0]   ack;
    logic [2:0]        owner;
    logic              locked;
    logic              serial_out;

    int checks = 0;
    int errors = 0;

    int          m_owner = NREQ - 1;
    bit          m_locked = 1'b0;
    int          m_phase = 0;
    int          wc = 0;
    logic [7:0]  exp_q[$];
    bit          dec_en = 1'b1;
    bit          dec_busy = 1'b0;

    always #5 clk = ~clk;

    xmtarb #(.NREQ(NREQ)) dut (
        .clk        (clk),
        .rst        (rst),
        .bit_len    (bit_len),
        .req        (req),
        .data       (data),
        .lock       (lock),
        .ack        (ack),
        .owner      (owner),
        .locked     (locked),
        .serial_out (serial_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: the model decides what a grant in this cycle must look like.
    task automatic step();
        logic [NREQ-1:0]   r;
        logic [NREQ-1:0]   l;
        logic [8*NREQ-1:0] d;
        int                exp_w;
        bit                rel;
        r = req;
        l = lock;
        d = data;
        @(posedge clk);
        #1;
        exp_w = -1;
        rel   = 1'b0;
        if (m_phase == 0) begin
            if (m_locked) begin
                rel = !l[m_owner];
                if (!rel && r[m_owner]) exp_w = m_owner;
            end else begin
                for (int k = 1; k <= NREQ; k++)
                    if (exp_w < 0 && r[(m_owner + k) % NREQ]) exp_w = (m_owner + k) % NREQ;
            end
            if (ack != '0) begin
                check("ack_winner", 32'(ack), (exp_w >= 0) ? (32'd1 << exp_w) : 32'd0);
                if (exp_w >= 0) begin
                    m_owner  = exp_w;
                    m_locked = l[exp_w];
                    exp_q.push_back(d[8*exp_w +: 8]);
                    m_phase  = 1;
                    wc       = 0;
                end
            end else begin
                if (rel) m_locked = 1'b0;
                if (exp_w >= 0) begin
                    wc++;
                    if (wc > 12 * int'(bit_len) + 10) begin
                        check("starved", 32'(wc), 32'd0);
                        wc = 0;
                    end
                end
            end
        end else begin
            check("ack_idle", 32'(ack), 32'd0);
            m_phase = (m_phase == 1) ? 2 : 0;
        end
        check("owner", 32'(owner), 32'(m_owner));
        check("locked", 32'(locked), 32'(m_locked));
    endtask

    task automatic wait_ack(input string tag, input int bound, output int who);
        who = -1;
        for (int i = 0; i < bound; i++) begin
            step();
            if (ack != '0) begin
                who = $clog2(ack);
                break;
            end
        end
        if (who < 0) check({tag, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (n < 2000 && !(exp_q.size() == 0 && !dec_busy && m_phase == 0 && !m_locked)) begin
            step();
            n++;
        end
        if (n >= 2000) check("drain_timeout", 32'd1, 32'd0);
        repeat (2 * int'(bit_len) + 4) step();
    endtask

    // Line decoder: samples mid-bit and matches bytes in grant order.
    initial begin
        logic [7:0] b;
        int         bl;
        forever begin
            @(negedge clk);
            if (dec_en && !rst && serial_out === 1'b0) begin
                dec_busy = 1'b1;
                bl = int'(bit_len);
                repeat (bl / 2) @(negedge clk);
                check("start_bit", 32'(serial_out), 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (bl) @(negedge clk);
                    b[i] = serial_out;
                end
                repeat (bl) @(negedge clk);
                check("stop_bit", 32'(serial_out), 32'd1);
                if (exp_q.size() == 0) check("serial_extra", 32'(b), 32'h100);
                else check("serial_byte", 32'(b), 32'(exp_q.pop_front()));
                dec_busy = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int who;
        int nacks;

        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_owner", 32'(owner), 32'(NREQ - 1));
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_line", 32'(serial_out), 32'd1);
        rst = 1'b0;

        // Single byte at bit_len 16.
        req = 4'b0100;
        data[23:16] = 8'h41;
        wait_ack("single", 50, who);
        check("single_who", 32'(who), 32'd2);
        req = '0;
        drain();

        // Fairness: all request, owner is 2 so service starts at 3.
        bit_len = 16'd4;
        req  = 4'b1111;
        data = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int n = 0; n < 6; n++) begin
            wait_ack("fair", 100, who);
            check("fair_order", 32'(who), 32'((3 + n) % NREQ));
        end
        req = '0;
        drain();

        // Locked three-byte message from 1 while 3 waits.
        req  = 4'b0010;
        lock = 4'b0010;
        data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        wait_ack("lock_first", 100, who);
        check("lock_first_who", 32'(who), 32'd1);
        req = 4'b1010;
        for (int n = 0; n < 2; n++) begin
            data[15:8] = 8'hB2 + 8'(n);
            wait_ack("lock_hold", 100, who);
            check("lock_hold_who", 32'(who), 32'd1);
        end
        lock = '0;
        wait_ack("lock_release", 100, who);
        check("lock_release_who", 32'(who), 32'd3);
        req = '0;
        drain();

        // Locked owner goes idle but keeps the lock.
        req  = 4'b0100;
        lock = 4'b0100;
        data = {8'h44, 8'h33, 8'h22, 8'h11};
        wait_ack("idle_lock", 100, who);
        check("idle_lock_who", 32'(who), 32'd2);
        req = 4'b0001;
        nacks = 0;
        for (int n = 0; n < 80; n++) begin
            step();
            if (ack != '0) nacks++;
        end
        check("idle_owner_block", 32'(nacks), 32'd0);
        lock = '0;
        wait_ack("idle_release", 100, who);
        check("idle_release_who", 32'(who), 32'd0);
        req = '0;
        drain();

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(3) == 0) req[i] = 1'($urandom_range(1));
                if ($urandom_range(11) == 0) lock[i] = ~lock[i];
            end
            data = $urandom;
            step();
        end
        req  = '0;
        lock = '0;
        drain();

        // Asynchronous reset during the data bits of a locked byte.
        dec_en  = 1'b0;
        bit_len = 16'd8;
        req     = 4'b0001;
        lock    = 4'b0001;
        data[7:0] = 8'h5A;
        wait_ack("pre_rst", 100, who);
        req = '0;
        repeat (30) step();
        check("pre_rst_locked", 32'(locked), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_ack", 32'(ack), 32'd0);
        check("arst_owner", 32'(owner), 32'(NREQ - 1));
        check("arst_locked", 32'(locked), 32'd0);
        @(posedge clk);
        #1;
        check("arst_line", 32'(serial_out), 32'd1);
        rst      = 1'b0;
        lock     = '0;
        m_owner  = NREQ - 1;
        m_locked = 1'b0;
        m_phase  = 0;
        wc       = 0;
        exp_q.delete();
        repeat (4) step();
        check("post_rst_line", 32'(serial_out), 32'd1);
        dec_en = 1'b1;
        req = 4'b0001;
        data[7:0] = 8'hC3;
        wait_ack("post_rst", 50, who);
        check("post_rst_who", 32'(who), 32'd0);
        req = '0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
